sr_ff_driver: RTL and testbench

Command sequencer that drives a bank of `WIDTH` SR flip-flops through their `s`/`r` inputs and confirms the result on their `q` outputs. It accepts a masked target-level request over a valid/ready handshake, then runs a fixed sequence: pulse `s`/`r`, settle, read `q` back, compare. Mismatched bits are retried up to `MAX_RETRY` times, and each request ends with a one-cycle completion report. It sits between control logic and SR flop banks and is the initiator side of the flops' `s`/`r` → `q` interface.

---
 rtl/sr_ff_driver_if.sv | 23 ++
 rtl/sr_ff_driver.sv | 103 ++++++++++
 tb/tb_sr_ff_driver.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sr_ff_driver_if.sv
// sr_ff_driver_if: request handshake, SR flop drive/readback and completion report
// of one sr_ff_driver channel.
interface sr_ff_driver_if #(parameter int WIDTH = 4);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_target;
    logic [WIDTH-1:0] req_mask;
    logic [WIDTH-1:0] s_out;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] q_in;
    logic             busy;
    logic             done_valid;
    logic             done_error;
    logic [WIDTH-1:0] done_mismatch;
    modport master (
        output req_valid, req_target, req_mask, q_in,
        input  req_ready, s_out, r_out, busy, done_valid, done_error, done_mismatch
    );
    modport slave (
        input  req_valid, req_target, req_mask, q_in,
        output req_ready, s_out, r_out, busy, done_valid, done_error, done_mismatch
    );
endinterface

// File: rtl/sr_ff_driver.sv
// sr_ff_driver: drives a bank of SR flops to a masked target level, reads q back
// and re-drives only the mismatched bits up to MAX_RETRY times.
module sr_ff_driver #(
    parameter int WIDTH         = 4,
    parameter int PULSE_CYCLES  = 2,
    parameter int SETTLE_CYCLES = 1,
    parameter int MAX_RETRY     = 1
) (
    input  logic          clk,
    input  logic          reset,
    sr_ff_driver_if.slave bus
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] DRIVE  = 3'd1;
    localparam logic [2:0] SETTLE = 3'd2;
    localparam logic [2:0] CHECK  = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;
    localparam int CW = $clog2((PULSE_CYCLES > SETTLE_CYCLES ? PULSE_CYCLES : SETTLE_CYCLES) + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);

    logic [2:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic [RW-1:0]    r_retry;
    logic [WIDTH-1:0] r_target;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_s;
    logic [WIDTH-1:0] r_r;
    logic             r_done_err;
    logic [WIDTH-1:0] r_done_mm;
    logic [WIDTH-1:0] w_mm;

    assign w_mm              = (bus.q_in ^ r_target) & r_mask;
    assign bus.req_ready     = r_state == IDLE;
    assign bus.busy          = r_state != IDLE;
    assign bus.done_valid    = r_state == DONE;
    assign bus.s_out         = r_s;
    assign bus.r_out         = r_r;
    assign bus.done_error    = r_done_err;
    assign bus.done_mismatch = r_done_mm;

    // s/r are derived from one target word, so a bit can never see S=R=1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_retry    <= '0;
            r_target   <= '0;
            r_mask     <= '0;
            r_s        <= '0;
            r_r        <= '0;
            r_done_err <= 1'b0;
            r_done_mm  <= '0;
        end else begin
            case (r_state)
                IDLE: if (bus.req_valid) begin
                    r_target <= bus.req_target;
                    r_mask   <= bus.req_mask;
                    r_retry  <= '0;
                    r_cnt    <= '0;
                    if (bus.req_mask == '0) begin
                        r_state    <= DONE;
                        r_done_err <= 1'b0;
                        r_done_mm  <= '0;
                    end else begin
                        r_state <= DRIVE;
                        r_s     <= bus.req_mask & bus.req_target;
                        r_r     <= bus.req_mask & ~bus.req_target;
                    end
                end
                DRIVE: if (r_cnt == CW'(PULSE_CYCLES - 1)) begin
                    r_state <= SETTLE;
                    r_cnt   <= '0;
                    r_s     <= '0;
                    r_r     <= '0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
                SETTLE: if (r_cnt == CW'(SETTLE_CYCLES - 1)) begin
                    r_state <= CHECK;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
                CHECK: if (w_mm == '0) begin
                    r_state    <= DONE;
                    r_done_err <= 1'b0;
                    r_done_mm  <= '0;
                end else if (r_retry < RW'(MAX_RETRY)) begin
                    r_state <= DRIVE;
                    r_retry <= r_retry + RW'(1);
                    r_s     <= w_mm & r_target;
                    r_r     <= w_mm & ~r_target;
                end else begin
                    r_state    <= DONE;
                    r_done_err <= 1'b1;
                    r_done_mm  <= w_mm;
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sr_ff_driver.sv
// tb_sr_ff_driver: table vectors, random requests against a retry-loop model,
// reset abort and back-to-back sequences for sr_ff_driver.
module tb_sr_ff_driver;
    localparam int P  = 2;
    localparam int S  = 1;
    localparam int MR = 1;

    typedef struct {
        logic [3:0] tgt;
        logic [3:0] mask;
        logic [3:0] q0;
        logic [3:0] stuck;
        int         k;
        logic       err;
        logic [3:0] mm;
        logic [3:0] qf;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sr_ff_driver_if #(.WIDTH(4)) bus();
    sr_ff_driver #(.WIDTH(4), .PULSE_CYCLES(P), .SETTLE_CYCLES(S), .MAX_RETRY(MR)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    // SR flop bank; S=R=1 forces 0, stuck bits read back as 0
    logic [3:0] q_raw = 4'b0;
    logic [3:0] stuck = 4'b0;
    logic [3:0] load_val = 4'b0;
    logic       load_en = 1'b0;
    assign bus.q_in = q_raw & ~stuck;
    always @(posedge clk)
        q_raw <= load_en ? load_val : (q_raw & ~bus.s_out & ~bus.r_out) | (bus.s_out & ~bus.r_out);

    int overlap_cnt = 0;
    int idle_drive_cnt = 0;
    always @(negedge clk) begin
        if ((bus.s_out & bus.r_out) != 4'b0) overlap_cnt++;
        if (!bus.busy && (bus.s_out | bus.r_out) != 4'b0) idle_drive_cnt++;
    end

    int n_cmp = 0;
    int n_fail = 0;
    int res_k, res_busy, res_drv, res_oob, res_rdy;
    logic res_err;
    logic [3:0] res_mm, res_q, res_s, res_r;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic load_q(input logic [3:0] v);
        @(negedge clk);
        load_val = v;
        load_en  = 1'b1;
        @(posedge clk);
        #1 load_en = 1'b0;
    endtask

    task automatic run_req(input logic [3:0] tgt, input logic [3:0] mask);
        int w;
        logic seen;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_target = tgt;
        bus.req_mask   = mask;
        w = 0;
        while (!bus.req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        res_k = -1; res_busy = 0; res_drv = 0; res_oob = 0; res_rdy = 0;
        res_err = 1'b0; res_mm = 4'b0; res_q = 4'b0; res_s = 4'b0; res_r = 4'b0;
        if (!bus.req_ready) begin
            chk("accept_timeout", 0, 1);
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            res_busy += int'(bus.busy);
            res_rdy  += int'(bus.req_ready);
            if ((bus.s_out | bus.r_out) != 4'b0) begin
                res_drv++;
                if (!seen) begin
                    res_s = bus.s_out;
                    res_r = bus.r_out;
                    seen  = 1'b1;
                end
            end
            if (((bus.s_out | bus.r_out) & ~mask) != 4'b0) res_oob++;
            if (bus.done_valid) begin
                res_k   = k;
                res_err = bus.done_error;
                res_mm  = bus.done_mismatch;
                res_q   = bus.q_in;
                break;
            end
        end
        if (res_k < 0) chk("done_timeout", 0, 1);
    endtask

    // Behavioural reference: repeated write attempts on the flop word.
    task automatic ref_model(input logic [3:0] tgt, input logic [3:0] mask, input logic [3:0] q0,
                             input logic [3:0] stk, output vec_t v);
        logic [3:0] drive, raw, m;
        int att;
        v.tgt = tgt; v.mask = mask; v.q0 = q0; v.stuck = stk;
        raw = q0; m = 4'b0; att = 0; drive = mask;
        if (mask != 4'b0) begin
            for (int a = 0; a <= MR; a++) begin
                raw = (raw & ~drive) | (drive & tgt);
                m   = ((raw & ~stk) ^ tgt) & mask;
                att = a + 1;
                if (m == 4'b0) break;
                drive = m;
            end
        end
        v.k = att * (P + S + 1); v.err = m != 4'b0; v.mm = m; v.qf = raw & ~stk;
    endtask

    task automatic apply_vec(input string tag, input vec_t v);
        stuck = v.stuck;
        load_q(v.q0);
        run_req(v.tgt, v.mask);
        chk({tag, "_lat"},    res_k, v.k);
        chk({tag, "_err"},    int'(res_err), int'(v.err));
        chk({tag, "_mm"},     int'(res_mm), int'(v.mm));
        chk({tag, "_q"},      int'(res_q), int'(v.qf));
        chk({tag, "_drvcyc"}, res_drv, (v.k / (P + S + 1)) * P);
        chk({tag, "_s"},      int'(res_s), int'(v.mask & v.tgt));
        chk({tag, "_r"},      int'(res_r), int'(v.mask & ~v.tgt));
        chk({tag, "_busy"},   res_busy, v.k + 1);
        chk({tag, "_oob"},    res_oob, 0);
        chk({tag, "_rdy"},    res_rdy, 0);
        @(negedge clk);
        chk({tag, "_hold_err"}, int'(bus.done_error), int'(v.err));
        chk({tag, "_hold_mm"},  int'(bus.done_mismatch), int'(v.mm));
        chk({tag, "_ready"},    int'(bus.req_ready), 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[5];
        vec_t v;
        int dv;
        tbl[0] = '{tgt: 4'b1010, mask: 4'b1111, q0: 4'b0000, stuck: 4'b0000, k: 4, err: 1'b0, mm: 4'b0000, qf: 4'b1010};
        tbl[1] = '{tgt: 4'b0000, mask: 4'b0110, q0: 4'b1111, stuck: 4'b0000, k: 4, err: 1'b0, mm: 4'b0000, qf: 4'b1001};
        tbl[2] = '{tgt: 4'b0100, mask: 4'b0100, q0: 4'b0000, stuck: 4'b0100, k: 8, err: 1'b1, mm: 4'b0100, qf: 4'b0000};
        tbl[3] = '{tgt: 4'b1111, mask: 4'b0000, q0: 4'b0011, stuck: 4'b0000, k: 0, err: 1'b0, mm: 4'b0000, qf: 4'b0011};
        tbl[4] = '{tgt: 4'b0011, mask: 4'b1111, q0: 4'b1100, stuck: 4'b0001, k: 8, err: 1'b1, mm: 4'b0001, qf: 4'b0010};
        bus.req_valid = 1'b0;
        bus.req_target = 4'b0;
        bus.req_mask = 4'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", int'(bus.req_ready), 1);
        chk("rst_busy",  int'(bus.busy), 0);
        chk("rst_s",     int'(bus.s_out), 0);
        chk("rst_r",     int'(bus.r_out), 0);
        chk("rst_done",  int'(bus.done_valid), 0);
        chk("rst_err",   int'(bus.done_error), 0);
        chk("rst_mm",    int'(bus.done_mismatch), 0);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) apply_vec($sformatf("vec%0d", i), tbl[i]);

        for (int i = 0; i < 25; i++) begin
            ref_model(4'($urandom), 4'($urandom), 4'($urandom),
                      ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0, v);
            apply_vec($sformatf("rnd%0d", i), v);
        end

        // abort in the first DRIVE cycle
        stuck = 4'b0;
        load_q(4'b0000);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_target = 4'b1111; bus.req_mask = 4'b1111;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        chk("abort_pre_s", int'(bus.s_out), 15);
        #1 reset = 1'b1;
        #1;
        chk("abort_s",     int'(bus.s_out), 0);
        chk("abort_r",     int'(bus.r_out), 0);
        chk("abort_busy",  int'(bus.busy), 0);
        chk("abort_ready", int'(bus.req_ready), 1);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        dv = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            dv += int'(bus.done_valid);
        end
        chk("abort_no_done", dv, 0);
        chk("abort_ready_after", int'(bus.req_ready), 1);
        apply_vec("post_abort", '{tgt: 4'b0110, mask: 4'b1111, q0: 4'b0000, stuck: 4'b0000,
                                  k: 4, err: 1'b0, mm: 4'b0000, qf: 4'b0110});

        // held request with a second payload queued behind the first
        load_q(4'b0000);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_target = 4'b0011; bus.req_mask = 4'b1111;
        @(posedge clk);
        #1 bus.req_target = 4'b1100; bus.req_mask = 4'b0011;
        res_k = -1; res_rdy = 0; res_s = 4'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            res_rdy += int'(bus.req_ready);
            if (k == 0) res_s = bus.s_out;
            if (bus.done_valid) begin
                res_k = k;
                break;
            end
        end
        chk("b2b_first_lat", res_k, 4);
        chk("b2b_first_s",   int'(res_s), 3);
        chk("b2b_no_accept", res_rdy, 0);
        @(negedge clk);
        chk("b2b_ready", int'(bus.req_ready), 1);
        chk("b2b_idle",  int'(bus.busy), 0);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        chk("b2b_second_busy", int'(bus.busy), 1);
        chk("b2b_second_s",    int'(bus.s_out), 0);
        chk("b2b_second_r",    int'(bus.r_out), 3);
        res_k = -1;
        for (int k = 1; k < 40; k++) begin
            @(negedge clk);
            if (bus.done_valid) begin
                res_k = k;
                res_err = bus.done_error;
                res_q = bus.q_in;
                break;
            end
        end
        chk("b2b_second_lat", res_k, 4);
        chk("b2b_second_err", int'(res_err), 0);
        chk("b2b_second_q",   int'(res_q), 0);

        chk("sr_overlap_cycles", overlap_cnt, 0);
        chk("drive_outside_busy", idle_drive_cnt, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
